la_capture_ctrl: RTL and testbench

//  Capture sequencer for the logic-analyser sample path. Accepts host commands, drives the

---
 rtl/la_pkg.sv | 36 +++
 rtl/la_strobe_stretch.sv | 44 ++++
 rtl/la_capture_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_la_capture_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/la_pkg.sv
// Shared definitions for the logic-analyser capture path: FSM states, host
// command op codes, trigger mode codes and reset defaults for the trigger setup.
package la_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARM       = 3'd1,
    ST_WAIT_TRIG = 3'd2,
    ST_CAPTURE   = 3'd3,
    ST_DONE      = 3'd4
  } la_state_e;

  typedef enum logic [1:0] {
    OP_ARM_SINGLE = 2'd0,
    OP_ARM_CONT   = 2'd1,
    OP_ABORT      = 2'd2,
    OP_RSVD       = 2'd3
  } la_op_e;

  typedef enum logic [2:0] {
    TRIG_LOW  = 3'd0,
    TRIG_HIGH = 3'd1,
    TRIG_POS  = 3'd2,
    TRIG_NEG  = 3'd3,
    TRIG_EDGE = 3'd4,
    TRIG_IMM  = 3'd5
  } la_trig_e;

  localparam logic [2:0] MODEL_RST   = TRIG_POS;
  localparam logic [7:0] CHANNEL_RST = 8'hFF;

  function automatic logic is_arm_op(input logic [1:0] op);
    return (op == OP_ARM_SINGLE) || (op == OP_ARM_CONT);
  endfunction

endpackage

// File: rtl/la_strobe_stretch.sv
// Stretches a one-cycle start request into a P_VLD_HOLD-cycle strobe so the
// sample generator's CDC edge detector is guaranteed to see it.
module la_strobe_stretch
  import la_pkg::*;
#(
  parameter int P_VLD_HOLD = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_start,
  input  logic i_clr,
  output logic o_vld,
  output logic o_last
);

  localparam int CW = $clog2(P_VLD_HOLD + 1);

  logic          vld_r;
  logic [CW-1:0] cnt_r;

  // Strobe level and remaining-cycle counter; clear wins over start.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vld_r <= 1'b0;
      cnt_r <= {CW{1'b0}};
    end else if (i_clr) begin
      vld_r <= 1'b0;
      cnt_r <= {CW{1'b0}};
    end else if (i_start) begin
      vld_r <= 1'b1;
      cnt_r <= CW'(P_VLD_HOLD - 1);
    end else if (vld_r) begin
      if (cnt_r == {CW{1'b0}}) begin
        vld_r <= 1'b0;
      end else begin
        cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
      end
    end
  end

  assign o_vld  = vld_r;
  assign o_last = vld_r && (cnt_r == {CW{1'b0}});

endmodule

// File: rtl/la_capture_ctrl.sv
// Capture sequencer: arms the sample generator, tracks trigger/capture/done,
// continuous re-arm and abort. Define CAPTURE_TIMEOUT_EN for the trigger timeout.
module la_capture_ctrl
  import la_pkg::*;
#(
  parameter int P_SEND_LEN = 1000,
  parameter int P_VLD_HOLD = 4,
  parameter int P_TIMEOUT  = 1000000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cmd_vld,
  input  logic [1:0]  i_cmd_op,
  input  logic [2:0]  i_cmd_model,
  input  logic [7:0]  i_cmd_channel,
  output logic        o_cmd_rdy,
  output logic        o_sam_vld,
  output logic [2:0]  o_sam_trig_model,
  output logic [7:0]  o_sam_trig_channel,
  input  logic        i_sam_data_vld,
  input  logic        i_sam_data_last,
  input  logic        i_up_rdy,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_len_err,
  output logic        o_timeout,
  output logic [15:0] o_frame_cnt
);

  localparam logic [12:0] SEND_LEN = 13'(P_SEND_LEN);

  la_state_e   state_r;
  logic        cont_r;
  logic        start_r;
  logic [12:0] beat_r;
  logic [2:0]  model_r;
  logic [7:0]  channel_r;
  logic        rdy_r;
  logic        busy_r;
  logic        done_r;
  logic        len_err_r;
  logic [15:0] frame_r;
  logic        abort_s;
  logic        arm_s;
  logic        strobe_last_s;
  logic [12:0] beat_inc_s;

  assign abort_s    = i_cmd_vld && (i_cmd_op == OP_ABORT);
  assign arm_s      = i_cmd_vld && is_arm_op(i_cmd_op);
  assign beat_inc_s = beat_r + {12'd0, i_sam_data_vld};

`ifdef CAPTURE_TIMEOUT_EN
  localparam logic [19:0] TO_LAST = 20'(P_TIMEOUT - 1);
  logic [19:0] to_cnt_r;
  logic        timeout_r;
`endif

  la_strobe_stretch #(.P_VLD_HOLD(P_VLD_HOLD)) u_stretch (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (start_r),
    .i_clr   (abort_s),
    .o_vld   (o_sam_vld),
    .o_last  (strobe_last_s)
  );

  // Sequencer FSM with its counters and registered status outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r   <= ST_IDLE;
      cont_r    <= 1'b0;
      start_r   <= 1'b0;
      beat_r    <= 13'd0;
      model_r   <= MODEL_RST;
      channel_r <= CHANNEL_RST;
      rdy_r     <= 1'b1;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      len_err_r <= 1'b0;
      frame_r   <= 16'd0;
`ifdef CAPTURE_TIMEOUT_EN
      to_cnt_r  <= 20'd0;
      timeout_r <= 1'b0;
`endif
    end else begin
      start_r   <= 1'b0;
      done_r    <= 1'b0;
      len_err_r <= 1'b0;
`ifdef CAPTURE_TIMEOUT_EN
      timeout_r <= 1'b0;
`endif
      if (abort_s) begin
        state_r <= ST_IDLE;
        cont_r  <= 1'b0;
        rdy_r   <= 1'b1;
        busy_r  <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (arm_s) begin
              model_r   <= i_cmd_model;
              channel_r <= i_cmd_channel;
              cont_r    <= (i_cmd_op == OP_ARM_CONT);
              frame_r   <= 16'd0;
              start_r   <= 1'b1;
              state_r   <= ST_ARM;
              rdy_r     <= 1'b0;
              busy_r    <= 1'b1;
            end
          end
          ST_ARM: begin
            if (strobe_last_s) begin
              state_r <= ST_WAIT_TRIG;
`ifdef CAPTURE_TIMEOUT_EN
              to_cnt_r <= 20'd0;
`endif
            end
          end
          ST_WAIT_TRIG: begin
            if (i_sam_data_vld) begin
              beat_r <= 13'd1;
              // A one-beat frame can carry last on its trigger beat.
              if (i_sam_data_last) begin
                state_r   <= ST_DONE;
                done_r    <= 1'b1;
                frame_r   <= frame_r + 16'd1;
                len_err_r <= (SEND_LEN != 13'd1);
              end else begin
                state_r <= ST_CAPTURE;
              end
            end
`ifdef CAPTURE_TIMEOUT_EN
            else if (to_cnt_r == TO_LAST) begin
              timeout_r <= 1'b1;
              state_r   <= ST_IDLE;
              cont_r    <= 1'b0;
              rdy_r     <= 1'b1;
              busy_r    <= 1'b0;
            end else begin
              to_cnt_r <= to_cnt_r + 20'd1;
            end
`endif
          end
          ST_CAPTURE: begin
            beat_r <= beat_inc_s;
            if (i_sam_data_last) begin
              state_r   <= ST_DONE;
              done_r    <= 1'b1;
              frame_r   <= frame_r + 16'd1;
              len_err_r <= (beat_inc_s != SEND_LEN);
            end
          end
          ST_DONE: begin
            if (cont_r && i_up_rdy) begin
              start_r <= 1'b1;
              state_r <= ST_ARM;
            end else if (!cont_r) begin
              state_r <= ST_IDLE;
              rdy_r   <= 1'b1;
              busy_r  <= 1'b0;
            end
          end
          default: begin
            state_r <= ST_IDLE;
            cont_r  <= 1'b0;
            rdy_r   <= 1'b1;
            busy_r  <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef CAPTURE_TIMEOUT_EN
  assign o_timeout = timeout_r;
`else
  if (P_TIMEOUT < 1) begin : g_bad_timeout
    $error("P_TIMEOUT must be positive");
  end
  assign o_timeout = 1'b0;
`endif

  assign o_cmd_rdy          = rdy_r;
  assign o_busy             = busy_r;
  assign o_done             = done_r;
  assign o_len_err          = len_err_r;
  assign o_frame_cnt        = frame_r;
  assign o_sam_trig_model   = model_r;
  assign o_sam_trig_channel = channel_r;

endmodule

// File: tb/tb_la_capture_ctrl.sv
// Directed-plus-random bench for la_capture_ctrl; expectations come from frame-level
// rules (pulse tallies, beat counts, frame totals) rather than cycle-level state.
module tb_la_capture_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_cmd_vld;
  logic [1:0]  i_cmd_op;
  logic [2:0]  i_cmd_model;
  logic [7:0]  i_cmd_channel;
  logic        o_cmd_rdy;
  logic        o_sam_vld;
  logic [2:0]  o_sam_trig_model;
  logic [7:0]  o_sam_trig_channel;
  logic        i_sam_data_vld;
  logic        i_sam_data_last;
  logic        i_up_rdy;
  logic        o_busy;
  logic        o_done;
  logic        o_len_err;
  logic        o_timeout;
  logic [15:0] o_frame_cnt;

  int total = 0;
  int bad   = 0;
  int done_seen, lerr_seen, both_seen, vld_hi, to_seen;

  la_capture_ctrl #(.P_SEND_LEN(1000), .P_VLD_HOLD(4), .P_TIMEOUT(100)) dut (
    .i_clk              (i_clk),
    .i_rst              (i_rst),
    .i_cmd_vld          (i_cmd_vld),
    .i_cmd_op           (i_cmd_op),
    .i_cmd_model        (i_cmd_model),
    .i_cmd_channel      (i_cmd_channel),
    .o_cmd_rdy          (o_cmd_rdy),
    .o_sam_vld          (o_sam_vld),
    .o_sam_trig_model   (o_sam_trig_model),
    .o_sam_trig_channel (o_sam_trig_channel),
    .i_sam_data_vld     (i_sam_data_vld),
    .i_sam_data_last    (i_sam_data_last),
    .i_up_rdy           (i_up_rdy),
    .o_busy             (o_busy),
    .o_done             (o_done),
    .o_len_err          (o_len_err),
    .o_timeout          (o_timeout),
    .o_frame_cnt        (o_frame_cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: advance to the falling edge and tally the pulse outputs seen there.
  task automatic tick();
    @(negedge i_clk);
    if (o_done === 1'b1) done_seen++;
    if (o_len_err === 1'b1) lerr_seen++;
    if (o_done === 1'b1 && o_len_err === 1'b1) both_seen++;
    if (o_sam_vld === 1'b1) vld_hi++;
    if (o_timeout === 1'b1) to_seen++;
  endtask

  task automatic clr_cnt();
    done_seen = 0; lerr_seen = 0; both_seen = 0; vld_hi = 0; to_seen = 0;
  endtask

  task automatic cmd(input logic [1:0] op, input logic [2:0] m, input logic [7:0] c);
    i_cmd_vld = 1'b1; i_cmd_op = op; i_cmd_model = m; i_cmd_channel = c;
    tick();
    i_cmd_vld = 1'b0;
  endtask

  // Arm, check the trigger setup leads the strobe, then wait out the strobe.
  task automatic arm(input logic [1:0] op, input logic [2:0] m, input logic [7:0] c);
    cmd(op, m, c);
    chk("arm_model", {29'd0, o_sam_trig_model}, {29'd0, m});
    chk("arm_channel", {24'd0, o_sam_trig_channel}, {24'd0, c});
    chk("arm_vld_lead", {31'd0, o_sam_vld}, 32'd0);
    chk("arm_busy", {31'd0, o_busy}, 32'd1);
    repeat (6) tick();
  endtask

  // Generator frame of n beats with random idle gaps; last flagged on beat last_at.
  task automatic beats(input int n, input int last_at);
    for (int k = 1; k <= n; k++) begin
      if ($urandom_range(7) == 0) begin
        i_sam_data_vld = 1'b0; i_sam_data_last = 1'b0;
        tick();
      end
      i_sam_data_vld = 1'b1;
      i_sam_data_last = (k == last_at);
      tick();
    end
    i_sam_data_vld = 1'b0; i_sam_data_last = 1'b0;
  endtask

  initial begin
    logic [2:0] m;
    logic [7:0] c;
    int n;
    i_rst = 1'b1; i_cmd_vld = 1'b0; i_cmd_op = 2'd0; i_cmd_model = 3'd0; i_cmd_channel = 8'd0;
    i_sam_data_vld = 1'b0; i_sam_data_last = 1'b0; i_up_rdy = 1'b1;
    repeat (2) @(negedge i_clk);
    chk("rst_vld", {31'd0, o_sam_vld}, 32'd0);
    chk("rst_model", {29'd0, o_sam_trig_model}, 32'd2);
    chk("rst_channel", {24'd0, o_sam_trig_channel}, 32'hFF);
    chk("rst_rdy", {31'd0, o_cmd_rdy}, 32'd1);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_frames", {16'd0, o_frame_cnt}, 32'd0);
    i_rst = 1'b0;

    // single shot, exact length
    clr_cnt();
    arm(2'd0, 3'd3, 8'h01);
    chk("t1_vld_cycles", vld_hi, 4);
    beats(1000, 1000);
    tick();
    chk("t1_done", done_seen, 1);
    chk("t1_lerr", lerr_seen, 0);
    chk("t1_frames", {16'd0, o_frame_cnt}, 32'd1);
    chk("t1_idle", {31'd0, o_cmd_rdy}, 32'd1);

    // continuous with uploader back-pressure
    clr_cnt();
    m = 3'($urandom_range(5)); c = 8'($urandom);
    arm(2'd1, m, c);
    beats(1000, 1000);
    chk("t2_frames1", {16'd0, o_frame_cnt}, 32'd1);
    repeat (6) tick();
    chk("t2_rearm1", vld_hi, 8);
    i_up_rdy = 1'b0;
    beats(1000, 1000);
    repeat (20) tick();
    chk("t2_hold_done", done_seen, 2);
    chk("t2_hold_frames", {16'd0, o_frame_cnt}, 32'd2);
    chk("t2_hold_no_arm", vld_hi, 8);
    chk("t2_hold_busy", {31'd0, o_busy}, 32'd1);
    i_up_rdy = 1'b1;
    repeat (7) tick();
    chk("t2_rearm2", vld_hi, 12);
    beats(1000, 1000);
    repeat (6) tick();
    chk("t2_done3", done_seen, 3);
    chk("t2_rearm3", vld_hi, 16);
    cmd(2'd2, 3'd0, 8'd0);
    chk("t2_abort_idle", {31'd0, o_busy}, 32'd0);
    chk("t2_frames_kept", {16'd0, o_frame_cnt}, 32'd3);

    // length errors: short frame then random length
    clr_cnt();
    arm(2'd0, 3'($urandom_range(5)), 8'($urandom));
    beats(998, 998);
    chk("t3_lerr", lerr_seen, 1);
    chk("t3_lerr_with_done", both_seen, 1);
    tick();
    clr_cnt();
    n = $urandom_range(995, 1005);
    arm(2'd0, 3'($urandom_range(5)), 8'($urandom));
    beats(n, n);
    tick();
    chk("t3_rand_lerr", lerr_seen, (n != 1000) ? 1 : 0);
    chk("t3_rand_done", done_seen, 1);

    // abort mid-capture, stale tail ignored
    clr_cnt();
    arm(2'd0, 3'd4, 8'h0F);
    beats(500, 0);
    cmd(2'd2, 3'd0, 8'd0);
    chk("t4_abort_rdy", {31'd0, o_cmd_rdy}, 32'd1);
    beats(500, 500);
    repeat (3) tick();
    chk("t4_no_done", done_seen, 0);
    chk("t4_no_lerr", lerr_seen, 0);
    chk("t4_frames", {16'd0, o_frame_cnt}, 32'd0);
    // abort coincident with last
    clr_cnt();
    arm(2'd0, 3'd1, 8'h80);
    beats(999, 0);
    i_sam_data_vld = 1'b1; i_sam_data_last = 1'b1;
    cmd(2'd2, 3'd0, 8'd0);
    i_sam_data_vld = 1'b0; i_sam_data_last = 1'b0;
    tick();
    chk("t4_abort_last_done", done_seen, 0);
    chk("t4_abort_last_idle", {31'd0, o_busy}, 32'd0);
    // abort while the strobe is high
    clr_cnt();
    cmd(2'd0, 3'd5, 8'h11);
    tick();
    cmd(2'd2, 3'd0, 8'd0);
    chk("t4_abort_drops_vld", {31'd0, o_sam_vld}, 32'd0);
    repeat (6) tick();
    chk("t4_abort_vld_cycles", vld_hi, 1);

    // trigger timeout
    clr_cnt();
    arm(2'd0, 3'd0, 8'h02);
    repeat (150) tick();
`ifdef CAPTURE_TIMEOUT_EN
    chk("t5_timeout", to_seen, 1);
    chk("t5_idle", {31'd0, o_busy}, 32'd0);
`else
    chk("t5_no_timeout", to_seen, 0);
    chk("t5_waiting", {31'd0, o_busy}, 32'd1);
`endif
    cmd(2'd2, 3'd0, 8'd0);
    chk("t5_abort", {31'd0, o_busy}, 32'd0);

    // arm while busy and reserved op are ignored
    clr_cnt();
    arm(2'd0, 3'd1, 8'h5A);
    cmd(2'd1, 3'd4, 8'hC3);
    chk("t6_model_kept", {29'd0, o_sam_trig_model}, 32'd1);
    chk("t6_channel_kept", {24'd0, o_sam_trig_channel}, 32'h5A);
    beats(1000, 1000);
    repeat (2) tick();
    chk("t6_single_done", done_seen, 1);
    chk("t6_single_idle", {31'd0, o_busy}, 32'd0);
    cmd(2'd3, 3'd4, 8'hC3);
    chk("t6_op3_ignored", {31'd0, o_busy}, 32'd0);

    // asynchronous reset during capture
    clr_cnt();
    arm(2'd1, 3'd5, 8'h3C);
    beats(1000, 1000);
    repeat (6) tick();
    beats(300, 0);
    chk("t6_pre_rst_frames", {16'd0, o_frame_cnt}, 32'd1);
    #2 i_rst = 1'b1;
    #1;
    chk("t6_rst_vld", {31'd0, o_sam_vld}, 32'd0);
    chk("t6_rst_model", {29'd0, o_sam_trig_model}, 32'd2);
    chk("t6_rst_channel", {24'd0, o_sam_trig_channel}, 32'hFF);
    chk("t6_rst_rdy", {31'd0, o_cmd_rdy}, 32'd1);
    chk("t6_rst_busy", {31'd0, o_busy}, 32'd0);
    chk("t6_rst_frames", {16'd0, o_frame_cnt}, 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    tick();
    chk("t6_post_rst_idle", {31'd0, o_busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
